// File: rtl/imm_gen_if.sv
// Bundle of the instruction-in and decoded-result-out handshakes of imm_gen_pipe.
//
// Handshake rule (both sides): a beat transfers on a rising clk edge where
// valid & ready are both 1. The sender holds valid and its payload stable
// until that edge. The receiver may move ready at any time.
//
//   in_valid/in_ready/in_instr/in_tag : fetch queue -> block
//   out_valid/out_ready/out_imm/out_fmt/out_illegal/out_tag : block -> issue
//
// Modport "slave" is the decoder's view. Modport "master" is the environment's
// view: it drives instructions and the downstream ready.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator with a 2-entry skid buffer.
//
// The block decodes one 32-bit instruction per cycle into an XLEN-wide
// immediate, a format class and an illegal flag. The result then passes
// through a main/skid register pair with one cycle of latency. A sideband
// tag travels with each instruction unchanged.
//
// Ports:
//   clk   : core clock, all state on the rising edge
//   rst   : synchronous active-high reset
//   flush : synchronous flush. It drops both entries and the input presented
//           that cycle.
//   bus   : imm_gen_if.slave (in_* instruction side, out_* result side)
//
// out_fmt: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input logic       clk,
  input logic       rst,
  input logic       flush,
  imm_gen_if.slave  bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_SHAMT = 3'd6, FMT_CSR = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  // ---------------- combinational decode ----------------
  logic [31:0] ins;
  logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [63:0] d_imm64;
  logic [2:0]  d_fmt;
  logic        d_ill;

  assign ins = bus.in_instr;

  // Every immediate is built at 64 bits and truncated to XLEN on capture.
  // This keeps a single decode path for both widths.
  always_comb begin
    imm_i = {{52{ins[31]}}, ins[31:20]};
    imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    imm_u = {{32{ins[31]}}, ins[31:12], 12'b0};

    d_imm64 = '0;
    d_fmt   = FMT_NONE;
    d_ill   = 1'b0;
    case (ins[6:0])
      OP_LOAD, OP_JALR:  begin d_imm64 = imm_i; d_fmt = FMT_I; end
      OP_STORE:          begin d_imm64 = imm_s; d_fmt = FMT_S; end
      OP_BRANCH:         begin d_imm64 = imm_b; d_fmt = FMT_B; end
      OP_JAL:            begin d_imm64 = imm_j; d_fmt = FMT_J; end
      OP_LUI, OP_AUIPC:  begin d_imm64 = imm_u; d_fmt = FMT_U; end
      OP_SYSTEM:         begin d_imm64 = {52'b0, ins[31:20]}; d_fmt = FMT_CSR; end
      OP_IMM: begin
        if (ins[13:12] == 2'b01) begin
          // funct3 001 (slli) or 101 (srli/srai). The 6-bit field is always
          // reported. On RV32 a set bit 25 is flagged illegal rather than
          // being masked off.
          d_imm64 = {58'b0, ins[25:20]};
          d_fmt   = FMT_SHAMT;
          d_ill   = !((ins[31:26] == 6'b000000) ||
                      (ins[31:26] == 6'b010000 && ins[14]));
          if (XLEN == 32 && ins[25]) d_ill = 1'b1;
        end else begin
          d_imm64 = imm_i;
          d_fmt   = FMT_I;
        end
      end
      default: d_ill = 1'b1;
    endcase
  end

  // ---------------- main + skid registers ----------------
  logic             main_valid, skid_valid;
  logic [XLEN-1:0]  main_imm, skid_imm;
  logic [2:0]       main_fmt, skid_fmt;
  logic             main_ill, skid_ill;
  logic [TAG_W-1:0] main_tag, skid_tag;

  logic accept, drain, main_free;

  // in_ready is the inverse of a flop output, so out_ready has no path to it.
  assign accept    = bus.in_valid & !skid_valid;
  assign drain     = main_valid & bus.out_ready;
  assign main_free = !main_valid | drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_imm   <= '0;
      main_fmt   <= '0;
      main_ill   <= 1'b0;
      main_tag   <= '0;
      skid_imm   <= '0;
      skid_fmt   <= '0;
      skid_ill   <= 1'b0;
      skid_tag   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // No input can be accepted while skid is full, so skid simply
        // moves forward and empties.
        main_valid <= 1'b1;
        main_imm   <= skid_imm;
        main_fmt   <= skid_fmt;
        main_ill   <= skid_ill;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_imm   <= d_imm64[XLEN-1:0];
        main_fmt   <= d_fmt;
        main_ill   <= d_ill;
        main_tag   <= bus.in_tag;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      // Main is stalled, so the new entry parks in skid.
      skid_valid <= 1'b1;
      skid_imm   <= d_imm64[XLEN-1:0];
      skid_fmt   <= d_fmt;
      skid_ill   <= d_ill;
      skid_tag   <= bus.in_tag;
    end
  end

  assign bus.in_ready    = !skid_valid;
  assign bus.out_valid   = main_valid;
  assign bus.out_imm     = main_imm;
  assign bus.out_fmt     = main_fmt;
  assign bus.out_illegal = main_ill;
  assign bus.out_tag     = main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe. It drives an XLEN=32 instance and an XLEN=64
// instance with identical stimulus. Both share one queue-based reference model.
module tb_imm_gen_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  imm_gen_if #(.XLEN(32), .TAG_W(8)) b32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(8)) b64 ();

  assign b32.in_valid = in_valid;
  assign b32.in_instr = in_instr;
  assign b32.in_tag = in_tag;
  assign b32.out_ready = out_ready;
  assign b64.in_valid = in_valid;
  assign b64.in_instr = in_instr;
  assign b64.in_tag = in_tag;
  assign b64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) d32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) d64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64.slave));

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference decode in signed arithmetic on the whole instruction word.
  function automatic void ref_decode(input logic [31:0] w, input int xlen,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic ill);
    longint s;
    longint sh, top;
    s = longint'($signed(w));
    imm = '0; fmt = 3'd0; ill = 1'b0;
    case (w[6:0])
      7'h03, 7'h67: begin fmt = 3'd1; imm = s >>> 20; end
      7'h23: begin fmt = 3'd2; imm = ((s >>> 25) <<< 5) | ((s >> 7) & 31); end
      7'h63: begin
        fmt = 3'd3;
        imm = ((s >>> 31) <<< 12) | (((s >> 7) & 1) << 11) |
              (((s >> 25) & 63) << 5) | (((s >> 8) & 15) << 1);
      end
      7'h6F: begin
        fmt = 3'd5;
        imm = ((s >>> 31) <<< 20) | (((s >> 12) & 255) << 12) |
              (((s >> 20) & 1) << 11) | (((s >> 21) & 1023) << 1);
      end
      7'h37, 7'h17: begin fmt = 3'd4; imm = (s >>> 12) <<< 12; end
      7'h73: begin fmt = 3'd7; imm = (s >> 20) & 4095; end
      7'h13: begin
        if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
          fmt = 3'd6;
          sh = (s >> 20) & 63;
          top = (s >> 26) & 63;
          imm = sh;
          ill = !(top == 0 || (top == 16 && w[14:12] == 3'b101)) || (xlen == 32 && sh >= 32);
        end else begin
          fmt = 3'd1; imm = s >>> 20;
        end
      end
      default: ill = 1'b1;
    endcase
    if (xlen == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
  endfunction

  typedef struct packed { logic [31:0] instr; logic [7:0] tag; } ent_t;
  ent_t mq[$];

  // The model is a FIFO of capacity 2. Ready means "not full". Pop happens
  // before push within one edge.
  always @(posedge clk) begin
    bit do_pop, do_push;
    if (rst || flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && out_ready;
      do_push = in_valid && (mq.size() < 2);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{in_instr, in_tag});
    end
  end

  always @(negedge clk) begin
    logic [63:0] ei;
    logic [2:0] ef;
    logic el;
    if (chk_en) begin
      chk("in_ready32", b32.in_ready, mq.size() < 2);
      chk("in_ready64", b64.in_ready, mq.size() < 2);
      chk("out_valid32", b32.out_valid, mq.size() > 0);
      chk("out_valid64", b64.out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        ref_decode(mq[0].instr, 32, ei, ef, el);
        chk("imm32", b32.out_imm, ei);
        chk("fmt32", b32.out_fmt, ef);
        chk("ill32", b32.out_illegal, el);
        chk("tag32", b32.out_tag, mq[0].tag);
        ref_decode(mq[0].instr, 64, ei, ef, el);
        chk("imm64", b64.out_imm, ei);
        chk("fmt64", b64.out_fmt, ef);
        chk("ill64", b64.out_illegal, el);
        chk("tag64", b64.out_tag, mq[0].tag);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] w, input logic [7:0] t);
    in_valid = 1'b1; in_instr = w; in_tag = t;
  endtask

  task automatic chk_out32(input string name, input logic [31:0] imm, input logic [2:0] fmt,
                           input logic ill, input logic [7:0] tag);
    chk({name, "_imm"}, b32.out_imm, imm);
    chk({name, "_fmt"}, b32.out_fmt, fmt);
    chk({name, "_ill"}, b32.out_illegal, ill);
    chk({name, "_tag"}, b32.out_tag, tag);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_v32"}, b32.out_valid, 1'b0);
    chk({name, "_r32"}, b32.in_ready, 1'b1);
    chk({name, "_imm32"}, b32.out_imm, 64'h0);
    chk({name, "_fmt32"}, b32.out_fmt, 3'd0);
    chk({name, "_ill32"}, b32.out_illegal, 1'b0);
    chk({name, "_tag32"}, b32.out_tag, 8'h00);
    chk({name, "_imm64"}, b64.out_imm, 64'h0);
    chk({name, "_tag64"}, b64.out_tag, 8'h00);
  endtask

  logic [31:0] tbl [12] = '{32'h00A12623, 32'h00812083, 32'h000080E7, 32'h30002573,
                            32'h4010D093, 32'h4200D093, 32'h40009093, 32'h00001017,
                            32'h80000063, 32'h800000EF, 32'h0000300F, 32'hFFF0A013};

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] li;
    logic [2:0] lf;
    logic ll;
    logic acc;
    int k;

    // Hand-derived values that pin the reference decoder itself.
    ref_decode(32'hFE000EE3, 32, li, lf, ll);
    chk("model_beq", li, 64'hFFFF_FFFC);
    ref_decode(32'h4200D093, 32, li, lf, ll);
    chk("model_srai32_ill", ll, 1'b1);
    ref_decode(32'h00A12623, 64, li, lf, ll);
    chk("model_sw", li, 64'h0000_0000_0000_000C);

    // Reset
    cyc();
    chk_en = 1'b1;
    cyc();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Back-to-back stream with out_ready held high
    out_ready = 1'b1;
    put(32'hFFF00093, 8'h10); cyc(); chk_out32("s_addi", 32'hFFFFFFFF, 3'd1, 1'b0, 8'h10);
    chk("s_addi_imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    put(32'h12345137, 8'h11); cyc(); chk_out32("s_lui", 32'h12345000, 3'd4, 1'b0, 8'h11);
    put(32'h0080006F, 8'h12); cyc(); chk_out32("s_jal", 32'h00000008, 3'd5, 1'b0, 8'h12);
    put(32'hFE000EE3, 8'h13); cyc(); chk_out32("s_beq", 32'hFFFFFFFC, 3'd3, 1'b0, 8'h13);

    // Shift width legality, RV64 LUI sign fill, unsupported opcodes
    put(32'h02109093, 8'h14); cyc();
    chk_out32("slli33_32", 32'h21, 3'd6, 1'b1, 8'h14);
    chk("slli33_imm64", b64.out_imm, 64'h21);
    chk("slli33_ill64", b64.out_illegal, 1'b0);
    put(32'h80000037, 8'h15); cyc();
    chk("lui64_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    put(32'h0000007F, 8'h16); cyc(); chk_out32("op7f", 32'h0, 3'd0, 1'b1, 8'h16);
    put(32'h00000000, 8'h17); cyc(); chk_out32("op00", 32'h0, 3'd0, 1'b1, 8'h17);
    chk("op00_imm64", b64.out_imm, 64'h0);
    in_valid = 1'b0; cyc();

    // Backpressure: tags 1 and 2 are accepted, tag 3 waits upstream.
    out_ready = 1'b0;
    put(32'h00100093, 8'h01); cyc();
    put(32'h00200093, 8'h02); cyc();
    chk("bp_in_ready_low", b32.in_ready, 1'b0);
    put(32'h00300093, 8'h03); cyc(); cyc();
    chk_out32("bp_stall_stable", 32'h1, 3'd1, 1'b0, 8'h01);
    out_ready = 1'b1; cyc();
    chk("bp_tag2", b32.out_tag, 8'h02);
    cyc();
    chk("bp_tag3", b32.out_tag, 8'h03);
    in_valid = 1'b0; cyc();
    chk("bp_empty", b32.out_valid, 1'b0);

    // Flush with both entries full and a valid input presented
    out_ready = 1'b0;
    put(32'h00500093, 8'h21); cyc();
    put(32'h00600093, 8'h22); cyc();
    put(32'h00700093, 8'h23); flush = 1'b1; cyc();
    flush = 1'b0;
    chk("flush_v", b32.out_valid, 1'b0);
    chk("flush_r", b32.in_ready, 1'b1);
    out_ready = 1'b1;
    put(32'h00800093, 8'h24); cyc();
    chk("flush_next_tag", b32.out_tag, 8'h24);
    in_valid = 1'b0; cyc();

    // Reset mid-stream while both entries are full
    out_ready = 1'b0;
    put(32'h12345137, 8'h31); cyc();
    put(32'hFFF00093, 8'h32); cyc();
    rst = 1'b1; cyc();
    chk_reset_vals("midrst");
    rst = 1'b0; out_ready = 1'b1;
    put(32'h0080006F, 8'h33); cyc();
    chk_out32("post_rst", 32'h8, 3'd5, 1'b0, 8'h33);
    in_valid = 1'b0; cyc();

    // Mixed table with intermittent backpressure; the model checks every cycle.
    k = 0;
    for (int i = 0; i < 12; i++) begin
      put(tbl[i], 8'h40 + 8'(i));
      do begin
        out_ready = (k % 3) != 1;
        acc = b32.in_ready;
        k++;
        cyc();
      end while (!acc && k < 200);
      if (!acc) chk("table_accept_timeout", 1'b0, 1'b1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
